// File: rtl/lab2_proc_imem_fetch_unit.sv
// -----------------------------------------------------------------------------
// lab2_proc_imem_fetch_unit
//
// Fetch front end of the 5-stage TinyRV2 pipeline. Owns the fetch PC, issues
// instruction-memory requests under a credit limit, drops responses that
// belong to squashed fetches, and buffers surviving {pc, inst} pairs in a
// small circular queue that feeds the decode stage.
//
// Handshake semantics (all val/rdy pairs on this block): a transfer happens
// in a cycle exactly when val && rdy are both high at the rising clock edge.
// A producer never makes val depend on rdy; imemresp_rdy is tied to 1
// because the credit limit guarantees space for every outstanding response.
//
// Parameters:
//   p_depth     max outstanding fetches (in-flight + queued), 1..8
//   p_reset_pc  first fetch address after reset
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   redirect, redirect_pc            squash younger fetches, restart fetch
//   imemreq_val/rdy/msg_addr         instruction-memory request
//   imemresp_val/rdy/msg_data        instruction-memory response (in order)
//   inst_val_D/inst_rdy_D/inst_D/pc_D  head of output queue to decode
//
// Optional build macro LAB2_PROC_FETCH_BYPASS_EN: when the output queue is
// empty, a surviving response is presented to decode in the same cycle and
// is consumed without being enqueued if decode accepts it.
// -----------------------------------------------------------------------------
module lab2_proc_imem_fetch_unit #(
  parameter int unsigned p_depth    = 2,
  parameter logic [31:0] p_reset_pc = 32'h200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imemreq_val,
  input  logic        imemreq_rdy,
  output logic [31:0] imemreq_msg_addr,
  input  logic        imemresp_val,
  output logic        imemresp_rdy,
  input  logic [31:0] imemresp_msg_data,
  output logic        inst_val_D,
  input  logic        inst_rdy_D,
  output logic [31:0] inst_D,
  output logic [31:0] pc_D
);

  localparam int CW = $clog2(p_depth + 1);
  localparam int PW = (p_depth > 1) ? $clog2(p_depth) : 1;

  // Circular pointer advance for a buffer that may not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(p_depth - 1)) ? '0 : p + PW'(1);
  endfunction

  // Fetch PC and occupancy counters
  logic [31:0]   pc_r;
  logic [CW-1:0] live_cnt;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] q_cnt;

  // PC FIFO: addresses of live in-flight requests; occupancy equals live_cnt
  logic [31:0]   pcf_mem [p_depth];
  logic [PW-1:0] pcf_wr;
  logic [PW-1:0] pcf_rd;

  // Output queue of {pc, inst}
  logic [31:0]   q_pc_mem   [p_depth];
  logic [31:0]   q_inst_mem [p_depth];
  logic [PW-1:0] q_wr;
  logic [PW-1:0] q_rd;

  // Control
  logic [31:0] credit_total;
  logic        req_fire;
  logic        resp_drop;
  logic        resp_live;
  logic        resp_counted;
  logic        q_empty;
  logic        bypass_val;
  logic        dec_fire;
  logic        q_push;
  logic        q_pop;
  logic [31:0] head_pc;

  // Credits count squashed in-flight requests too, so a burst of stale
  // responses can never overrun the output queue.
  assign credit_total = 32'(live_cnt) + 32'(drop_cnt) + 32'(q_cnt);
  assign imemreq_val  = !reset && !redirect && (credit_total < 32'(p_depth));
  assign imemreq_msg_addr = pc_r;
  assign imemresp_rdy = 1'b1;

  assign req_fire     = imemreq_val && imemreq_rdy;
  // Responses return in order, so all squashed ones precede any live one.
  assign resp_drop    = imemresp_val && (drop_cnt != '0);
  // A response with nothing outstanding is ignored rather than underflowing.
  assign resp_live    = imemresp_val && (drop_cnt == '0) && (live_cnt != '0);
  assign resp_counted = resp_drop || resp_live;

  assign head_pc = pcf_mem[pcf_rd];
  assign q_empty = (q_cnt == '0);

`ifdef LAB2_PROC_FETCH_BYPASS_EN
  assign bypass_val = q_empty && resp_live && !redirect;
`else
  assign bypass_val = 1'b0;
`endif

  assign inst_val_D = !q_empty || bypass_val;
  assign inst_D     = !q_empty  ? q_inst_mem[q_rd]  :
                      bypass_val ? imemresp_msg_data : 32'd0;
  assign pc_D       = !q_empty  ? q_pc_mem[q_rd]    :
                      bypass_val ? head_pc           : 32'd0;

  // Redirect overrides a decode fire in the same cycle.
  assign dec_fire = inst_val_D && inst_rdy_D && !redirect;
  assign q_pop    = dec_fire && !q_empty;
  // A bypassed entry taken by decode never enters the queue.
  assign q_push   = resp_live && !redirect && !(bypass_val && inst_rdy_D);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r     <= p_reset_pc;
      live_cnt <= '0;
      drop_cnt <= '0;
      q_cnt    <= '0;
      pcf_wr   <= '0;
      pcf_rd   <= '0;
      q_wr     <= '0;
      q_rd     <= '0;
    end else if (redirect) begin
      // Every live request becomes a drop; a response accepted this cycle
      // retires one outstanding request whichever class it belonged to.
      pc_r     <= redirect_pc;
      live_cnt <= '0;
      drop_cnt <= drop_cnt + live_cnt - CW'(resp_counted);
      q_cnt    <= '0;
      pcf_wr   <= '0;
      pcf_rd   <= '0;
      q_wr     <= '0;
      q_rd     <= '0;
    end else begin
      if (req_fire) begin
        pc_r   <= pc_r + 32'd4;
        pcf_wr <= ptr_inc(pcf_wr);
      end
      if (resp_live) pcf_rd <= ptr_inc(pcf_rd);
      if (q_push)    q_wr   <= ptr_inc(q_wr);
      if (q_pop)     q_rd   <= ptr_inc(q_rd);
      live_cnt <= live_cnt + CW'(req_fire) - CW'(resp_live);
      drop_cnt <= drop_cnt - CW'(resp_drop);
      q_cnt    <= q_cnt + CW'(q_push) - CW'(q_pop);
    end
  end

  // Storage needs no reset: entries are only read when counted as valid.
  always_ff @(posedge clk) begin
    if (req_fire) pcf_mem[pcf_wr] <= pc_r;
    if (q_push) begin
      q_pc_mem[q_wr]   <= head_pc;
      q_inst_mem[q_wr] <= imemresp_msg_data;
    end
  end

endmodule

// File: tb/tb_lab2_proc_imem_fetch_unit.sv
module tb_lab2_proc_imem_fetch_unit;

  localparam int DEPTH = 2;

  // ---------------------------------------------------------------- clock/reset
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imemreq_val;
  logic        imemreq_rdy = 1'b0;
  logic [31:0] imemreq_msg_addr;
  logic        imemresp_val = 1'b0;
  logic        imemresp_rdy;
  logic [31:0] imemresp_msg_data = '0;
  logic        inst_val_D;
  logic        inst_rdy_D = 1'b0;
  logic [31:0] inst_D;
  logic [31:0] pc_D;

  always #5 clk = ~clk;

  lab2_proc_imem_fetch_unit #(.p_depth(DEPTH), .p_reset_pc(32'h200)) dut (
    .clk(clk), .reset(reset),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy),
    .imemreq_msg_addr(imemreq_msg_addr),
    .imemresp_val(imemresp_val), .imemresp_rdy(imemresp_rdy),
    .imemresp_msg_data(imemresp_msg_data),
    .inst_val_D(inst_val_D), .inst_rdy_D(inst_rdy_D),
    .inst_D(inst_D), .pc_D(pc_D)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Driver knobs
  logic        drv_redirect = 1'b0;
  logic [31:0] drv_redirect_pc = '0;
  logic        drv_req_rdy = 1'b1;
  logic        drv_inst_rdy = 1'b1;
  int          mem_lat = 1;

  // Memory model: in-order responses, each no earlier than its latency
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  int          mem_last_due = -1;

  // Behavioural model: every fetch issued in the current epoch survives;
  // an epoch ends at each redirect. Delivered pairs wait in exp queues.
  logic [31:0] m_pc;
  int          m_epoch;
  logic [31:0] fly_pc_q[$];
  int          fly_ep_q[$];
  logic [31:0] exp_q[$];       // expected pc_D sequence
  logic [31:0] exp_inst_q[$];  // expected inst_D sequence

  // Per-cycle values carried from drive phase to commit phase
  logic        resp_v_r, resp_live_r, e_val_r, e_req_val_r;
  logic        dut_fire_r;
  logic [31:0] dut_addr_r;
  int          n_deliv;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 ^ a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_pc = 32'h200;
    m_epoch = 0;
    fly_pc_q.delete(); fly_ep_q.delete();
    exp_q.delete(); exp_inst_q.delete();
    mem_addr_q.delete(); mem_due_q.delete();
    mem_last_due = -1;
  endtask

  // Asynchronous reset pulse, possibly with traffic still in flight
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    redirect = 1'b0; imemreq_rdy = 1'b0; imemresp_val = 1'b0;
    imemresp_msg_data = '0; inst_rdy_D = 1'b0;
    #1;
    check("rst_req_val", imemreq_val, 0);
    check("rst_req_addr", imemreq_msg_addr, 32'h200);
    check("rst_inst_val", inst_val_D, 0);
    check("rst_inst", inst_D, 0);
    check("rst_pc", pc_D, 0);
    model_clear();
    drv_redirect = 1'b0; drv_req_rdy = 1'b1; drv_inst_rdy = 1'b1; mem_lat = 1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Drive phase: apply inputs at negedge, then compare against the model
  task automatic cyc_drive();
    logic        e_req_val, e_val;
    logic [31:0] e_pc, e_inst;
    @(negedge clk);
    redirect = drv_redirect;
    redirect_pc = drv_redirect_pc;
    imemreq_rdy = drv_req_rdy;
    inst_rdy_D = drv_inst_rdy;
    resp_v_r = (mem_due_q.size() != 0) && (mem_due_q[0] <= cyc);
    imemresp_val = resp_v_r;
    imemresp_msg_data = resp_v_r ? mem_word(mem_addr_q[0]) : 32'd0;
    #1;
    if (resp_v_r) check("resp_has_request", 32'(fly_pc_q.size() != 0), 1);
    resp_live_r = resp_v_r && (fly_pc_q.size() != 0) && !drv_redirect &&
                  (fly_ep_q[0] == m_epoch);
    e_req_val = !drv_redirect && ((fly_pc_q.size() + exp_q.size()) < DEPTH);
    e_val  = exp_q.size() != 0;
    e_pc   = e_val ? exp_q[0] : 32'd0;
    e_inst = e_val ? exp_inst_q[0] : 32'd0;
`ifdef LAB2_PROC_FETCH_BYPASS_EN
    if (!e_val && resp_live_r) begin
      e_val = 1'b1; e_pc = fly_pc_q[0]; e_inst = mem_word(fly_pc_q[0]);
    end
`endif
    check("req_val", imemreq_val, e_req_val);
    if (e_req_val) check("req_addr", imemreq_msg_addr, m_pc);
    check("resp_rdy", imemresp_rdy, 1);
    check("inst_val", inst_val_D, e_val);
    check("inst_D", inst_D, e_inst);
    check("pc_D", pc_D, e_pc);
    e_val_r = e_val;
    e_req_val_r = e_req_val;
    dut_fire_r = imemreq_val && imemreq_rdy;
    dut_addr_r = imemreq_msg_addr;
  endtask

  // Commit phase: advance memory and model across the rising edge
  task automatic cyc_commit();
    logic byp;
    int   due;
    @(posedge clk);
    if (resp_v_r) begin
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end
    if (dut_fire_r) begin
      due = cyc + mem_lat;
      if (due <= mem_last_due) due = mem_last_due + 1;
      mem_addr_q.push_back(dut_addr_r);
      mem_due_q.push_back(due);
      mem_last_due = due;
    end
    if (resp_v_r && fly_pc_q.size() != 0) begin
      if (resp_live_r) begin
        exp_q.push_back(fly_pc_q[0]);
        exp_inst_q.push_back(mem_word(fly_pc_q[0]));
      end
      void'(fly_pc_q.pop_front());
      void'(fly_ep_q.pop_front());
    end
    if (drv_redirect) begin
      exp_q.delete(); exp_inst_q.delete();
      m_epoch++;
      m_pc = drv_redirect_pc;
    end else begin
      if (e_val_r && drv_inst_rdy) begin
        // Either the queue head or (with bypass) the just-pushed response
        void'(exp_q.pop_front());
        void'(exp_inst_q.pop_front());
        n_deliv++;
      end
      if (e_req_val_r && drv_req_rdy) begin
        fly_pc_q.push_back(m_pc);
        fly_ep_q.push_back(m_epoch);
        m_pc = m_pc + 32'd4;
      end
    end
    byp = 1'b0;
    cyc++;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      cyc_drive();
      cyc_commit();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        found;
    logic        have_prev;
    logic [31:0] prev_pc;
    model_clear();
    n_deliv = 0;

    // Test 1: streaming fetch, memory latency 1, decode always ready
    do_reset();
    cyc_drive();
    check("t1_first_addr", imemreq_msg_addr, 32'h200);
    check("t1_first_val", imemreq_val, 1);
    cyc_commit();
    cyc_drive();
    check("t1_second_addr", imemreq_msg_addr, 32'h204);
`ifdef LAB2_PROC_FETCH_BYPASS_EN
    check("t1_byp_pc", pc_D, 32'h200);
    check("t1_byp_inst", inst_D, 32'hA000_0200);
`else
    check("t1_no_early_val", inst_val_D, 0);
`endif
    cyc_commit();
    cyc_drive();
`ifndef LAB2_PROC_FETCH_BYPASS_EN
    check("t1_pc", pc_D, 32'h200);
    check("t1_inst", inst_D, 32'hA000_0200);
`endif
    cyc_commit();
    cycles(20);

    // Test 2: decode stalled, credits cap outstanding fetches at 2
    do_reset();
    drv_inst_rdy = 1'b0;
    cycles(3);
    cyc_drive();
    check("t2_stall_no_req", imemreq_val, 0);
    check("t2_head_pc", pc_D, 32'h200);
    cyc_commit();
    drv_inst_rdy = 1'b1;
    cyc_drive();
    check("t2_still_no_req", imemreq_val, 0);
    cyc_commit();
    drv_inst_rdy = 1'b0;
    cyc_drive();
    check("t2_req_val", imemreq_val, 1);
    check("t2_req_addr", imemreq_msg_addr, 32'h208);
    check("t2_head_pc2", pc_D, 32'h204);
    cyc_commit();
    drv_inst_rdy = 1'b1;
    cycles(10);

    // Test 3: redirect with two fetches in flight, latency 3
    do_reset();
    mem_lat = 3;
    cycles(2);
    drv_redirect = 1'b1; drv_redirect_pc = 32'h300;
    cycles(1);
    drv_redirect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc_drive();
      check("t3_squashed_quiet", inst_val_D, 0);
      cyc_commit();
    end
    cyc_drive();
`ifdef LAB2_PROC_FETCH_BYPASS_EN
    check("t3_first_pc", pc_D, 32'h300);
    check("t3_first_inst", inst_D, 32'hA000_0300);
    cyc_commit();
`else
    check("t3_quiet_last", inst_val_D, 0);
    cyc_commit();
    cyc_drive();
    check("t3_first_pc", pc_D, 32'h300);
    check("t3_first_inst", inst_D, 32'hA000_0300);
    cyc_commit();
`endif
    cycles(10);

    // Test 4: redirect together with a response and a decode fire
    do_reset();
    mem_lat = 2;
    drv_inst_rdy = 1'b0;
    cycles(3);
    drv_redirect = 1'b1; drv_redirect_pc = 32'h300; drv_inst_rdy = 1'b1;
    cyc_drive();
    check("t4_queued_visible", pc_D, 32'h200);
    cyc_commit();
    drv_redirect = 1'b0;
    cyc_drive();
    check("t4_req_val", imemreq_val, 1);
    check("t4_req_addr", imemreq_msg_addr, 32'h300);
    check("t4_flushed", inst_val_D, 0);
    cyc_commit();
    cycles(10);

    // Test 5: back-to-back redirects, latency 3
    do_reset();
    mem_lat = 3;
    cycles(2);
    drv_redirect = 1'b1; drv_redirect_pc = 32'h300;
    cycles(1);
    drv_redirect_pc = 32'h400;
    cycles(1);
    drv_redirect = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      cyc_drive();
      if (inst_val_D) begin
        found = 1'b1;
        check("t5_first_pc", pc_D, 32'h400);
      end
      cyc_commit();
    end
    check("t5_delivered", 32'(found), 1);
    cycles(6);

    // Test 6: random memory readiness, latency and decode backpressure
    do_reset();
    n_deliv = 0;
    have_prev = 1'b0;
    prev_pc = '0;
    for (int i = 0; i < 1000; i++) begin
      drv_req_rdy = 1'($urandom_range(0, 1));
      drv_inst_rdy = 1'($urandom_range(0, 1));
      mem_lat = $urandom_range(1, 3);
      cyc_drive();
      if (inst_val_D && drv_inst_rdy) begin
        if (have_prev) check("t6_sequential", pc_D, prev_pc + 32'd4);
        have_prev = 1'b1;
        prev_pc = pc_D;
      end
      cyc_commit();
    end
    check("t6_progress", 32'(n_deliv > 50), 1);

    // Reset while traffic is outstanding
    do_reset();
    cycles(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lab2_proc_imem_fetch_unit.md
Name: lab2_proc_imem_fetch_unit

Overview:
- Front end of the 5-stage TinyRV2 pipeline. Owns the fetch PC and issues instruction-memory requests.
- Tracks in-flight requests and discards responses that belong to squashed (redirected) fetches.
- Buffers surviving {pc, inst} pairs in a small queue that feeds the decode-stage registers over a val/rdy interface.
- Replaces ad-hoc drop logic with a credit-based, fully decoupled fetch.

Parameters:
- p_depth, 2, max outstanding fetches (in-flight requests + queued instructions); legal range 1..8.
- p_reset_pc, 32'h200, first fetch address after reset.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- redirect  input  1  squash all younger fetches and restart at redirect_pc (branch/jal resolved)
- redirect_pc  input  32  new fetch PC
- imemreq_val  output  1  request valid
- imemreq_rdy  input  1  memory ready
- imemreq_msg_addr  output  32  fetch address (current fetch PC)
- imemresp_val  input  1  response valid
- imemresp_rdy  output  1  always 1 (credits guarantee space)
- imemresp_msg_data  input  32  fetched instruction word
- inst_val_D  output  1  instruction available for decode
- inst_rdy_D  input  1  decode accepts (reg_en_D)
- inst_D  output  32  head instruction, 0 when empty
- pc_D  output  32  PC of head instruction, 0 when empty

Behaviour:
- Reset (async, active-high): fetch PC = p_reset_pc. All counters 0; both queues empty; imemreq_val = 0; inst_val_D = 0; inst_D = pc_D = 0. The first request is issued in the first cycle after reset deasserts.
- Counters:
  - live_cnt: in-flight requests that are not squashed.
  - drop_cnt: in-flight requests that are squashed.
  - q_cnt: occupancy of the output queue.
  - Each counter is clog2(p_depth+1) bits wide and must never exceed p_depth.
- Credit rule: imemreq_val = !reset && !redirect && (live_cnt + drop_cnt + q_cnt < p_depth).
- Request fire (val && rdy):
  - Push the fetch PC into the PC FIFO (depth p_depth).
  - live_cnt++.
  - PC <= PC + 4 (32-bit wrap).
  - imemreq_msg_addr changes only after the fire.
- Response fire (imemresp_val):
  - If drop_cnt > 0: drop_cnt-- and discard the data.
  - Otherwise: pop the PC FIFO, live_cnt--, and push {pc, data} into the output queue.
  - Responses return in order. A response that arrives with live_cnt = drop_cnt = 0 is a protocol error; the verification bench asserts on it.
- Decode fire (inst_val_D && inst_rdy_D): pop the output queue.
- Output queue:
  - Registered circular buffer, depth p_depth.
  - inst_val_D = (q_cnt != 0).
  - Response-to-inst_val_D latency is 1 cycle.
  - Push and pop may occur in the same cycle, including when the queue is full, because credits prevent overflow.
- Redirect (has priority over every other event in that cycle):
  - PC <= redirect_pc.
  - No request is issued that cycle.
  - Output queue and PC FIFO are flushed (q_cnt = 0). A decode fire in the same cycle is ignored; inst_val_D drops next cycle.
  - drop_cnt <= drop_cnt + live_cnt − (response fire this cycle ? 1 : 0).
  - live_cnt <= 0.
  - A response accepted in the redirect cycle is discarded.
  - Back-to-back redirects accumulate drops correctly.
- Reset asserted mid-operation: all state clears immediately. Any responses still outstanding afterwards are the memory's responsibility; memory is reset together with the fetch unit.

Optional Feature:
- Macro LAB2_PROC_FETCH_BYPASS_EN.
- Defined: when the output queue is empty, a non-dropped response in a non-redirect cycle drives inst_val_D/inst_D/pc_D combinationally that same cycle (0-cycle latency). If inst_rdy_D = 1, the entry is consumed without being enqueued; otherwise it is enqueued as normal.
- Undefined: no combinational path from imemresp to the decode outputs; latency is always 1 cycle.

Test Plan:
- Reset release, memory always ready, 1-cycle response → requests issued at 0x200, 0x204, 0x208…; decode sees pc_D = 0x200 with inst_D = first word one cycle after the response (same cycle with BYPASS).
- inst_rdy_D held 0, p_depth = 2 → exactly 2 requests issued (0x200, 0x204), then imemreq_val = 0 until the first decode fire, which frees one credit and issues 0x208.
- Redirect to 0x300 while 2 requests are in flight → the next 2 responses are discarded, inst_val_D stays 0, and the next delivered instruction has pc_D = 0x300.
- Redirect in the same cycle as a response and a decode fire, with 1 request in flight and 1 queued → queue flushed, drop_cnt = 0 afterwards, next request 0x300 issued the following cycle.
- Two redirects 1 cycle apart (0x300, then 0x400) with memory latency 3 → all stale responses dropped; first delivered pc_D = 0x400.
- imemreq_rdy toggling randomly for 1000 cycles with random inst_rdy_D → delivered PCs strictly sequential (+4), with no loss or duplication and counters always ≤ p_depth.
